// File: rtl/gray_scale_pipe_pkg.sv
// Shared types and constants for the grayscale pipeline and its kernel.
package gray_pkg;

  typedef enum logic [1:0] {
    MODE_AVG  = 2'd0,
    MODE_LUMA = 2'd1,
    MODE_MAX  = 2'd2
  } mode_e;

  // BT.601 weights scaled by 256; they sum to 256 so luma never overflows.
  localparam int LUMA_WR    = 77;
  localparam int LUMA_WG    = 150;
  localparam int LUMA_WB    = 29;
  localparam int LUMA_SHIFT = 8;

endpackage

// File: rtl/gray_scale_pipe_if.sv
// FIFO-side handshake and pixel bus for gray_scale_pipe.
// master = FIFO/environment side, slave = the pipeline.
interface gray_scale_pipe_if #(parameter int DATA_WIDTH = 8);
  logic                  input_empty;
  logic                  output_full;
  logic [DATA_WIDTH-1:0] red;
  logic [DATA_WIDTH-1:0] green;
  logic [DATA_WIDTH-1:0] blue;
  logic [1:0]            cfg_mode;
  logic                  read_fifo;
  logic                  write_fifo;
  logic [DATA_WIDTH-1:0] gray_image;
  logic                  frame_done;

  modport master (
    output input_empty, output_full, red, green, blue, cfg_mode,
    input  read_fifo, write_fifo, gray_image, frame_done
  );

  modport slave (
    input  input_empty, output_full, red, green, blue, cfg_mode,
    output read_fifo, write_fifo, gray_image, frame_done
  );
endinterface

// File: rtl/gray_scale_pipe_kernel.sv
// Combinational RGB -> gray kernel: average, BT.601 luma or channel max.
// Mode code 3 is unused and falls back to average.
module gray_kernel
  import gray_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] red,
  input  logic [DATA_WIDTH-1:0] green,
  input  logic [DATA_WIDTH-1:0] blue,
  input  logic [1:0]            mode,
  output logic [DATA_WIDTH-1:0] gray
);
  localparam int SW = DATA_WIDTH + 2;
  localparam int LW = DATA_WIDTH + 8;

  logic [SW-1:0]         sum;
  logic [LW-1:0]         luma_acc;
  logic [DATA_WIDTH-1:0] mx_rg;
  logic [DATA_WIDTH-1:0] mx;

  assign sum      = SW'(red) + SW'(green) + SW'(blue);
  assign luma_acc = LW'(LUMA_WR) * LW'(red) + LW'(LUMA_WG) * LW'(green)
                  + LW'(LUMA_WB) * LW'(blue);
  assign mx_rg    = (red > green) ? red : green;
  assign mx       = (mx_rg > blue) ? mx_rg : blue;

  // Select the kernel result; truncations are exact since each result fits DATA_WIDTH.
  always_comb begin
    gray = DATA_WIDTH'(sum / SW'(3));
    case (mode)
      MODE_LUMA: gray = DATA_WIDTH'(luma_acc >> LUMA_SHIFT);
      MODE_MAX:  gray = mx;
      default:   gray = DATA_WIDTH'(sum / SW'(3));
    endcase
  end
endmodule

// File: rtl/gray_scale_pipe.sv
// Two-stage stallable RGB -> gray pipeline between an FWFT input FIFO and an
// output FIFO. Kernel mode is latched on the first pop of every frame.
module gray_scale_pipe
  import gray_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FRAME_PIXELS = 64
) (
  input logic               clk,
  input logic               rst,
  gray_scale_pipe_if.slave  bus
);
  localparam int            CW       = $clog2(FRAME_PIXELS);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_PIXELS - 1);

  logic                  adv, pop;
  logic [CW-1:0]         in_cnt;
  logic [1:0]            mode_q, pix_mode;
  logic                  s1_valid, s1_last;
  logic [DATA_WIDTH-1:0] s1_r, s1_g, s1_b;
  logic [1:0]            s1_mode;
  logic                  s2_valid, s2_last;
  logic [DATA_WIDTH-1:0] s2_gray, k_gray;

  // A bubble in S2 never blocks; only a valid S2 facing a full FIFO stalls.
  assign adv      = !(s2_valid && bus.output_full);
  assign pop      = !rst && !bus.input_empty && adv;
  // The first pixel of a frame uses the live cfg_mode, later ones the latch.
  assign pix_mode = (in_cnt == '0) ? bus.cfg_mode : mode_q;

  gray_kernel #(.DATA_WIDTH(DATA_WIDTH)) u_kernel (
    .red(s1_r), .green(s1_g), .blue(s1_b), .mode(s1_mode), .gray(k_gray)
  );

  // Frame pixel counter and per-frame mode latch, both advance on pops only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt <= '0;
      mode_q <= MODE_AVG;
    end else if (pop) begin
      in_cnt <= (in_cnt == LAST_IDX) ? '0 : in_cnt + 1'b1;
      if (in_cnt == '0) mode_q <= bus.cfg_mode;
    end
  end

  // S1: registered pixel, mode and last tag; loads a bubble when nothing pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_mode  <= MODE_AVG;
    end else if (adv) begin
      s1_valid <= pop;
      if (pop) begin
        s1_r    <= bus.red;
        s1_g    <= bus.green;
        s1_b    <= bus.blue;
        s1_mode <= pix_mode;
        s1_last <= (in_cnt == LAST_IDX);
      end
    end
  end

  // S2: registered gray result; data holds across bubbles so the output is quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_gray  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_gray <= k_gray;
        s2_last <= s1_last;
      end
    end
  end

  assign bus.read_fifo  = pop;
  assign bus.write_fifo = s2_valid && !bus.output_full;
  assign bus.gray_image = s2_gray;
  assign bus.frame_done = s2_valid && !bus.output_full && s2_last;
endmodule

// File: tb/tb_gray_scale_pipe.sv
// Scoreboard bench for gray_scale_pipe: expected gray values are pushed when
// a pop is seen and compared when the pipeline pushes.
module tb_gray_scale_pipe;
  localparam int FP = 4;

  typedef struct { int r; int g; int b; } pix_t;
  typedef struct { logic [7:0] gray; bit last; int cyc; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gray_scale_pipe_if #(.DATA_WIDTH(8)) bus ();
  gray_scale_pipe #(.DATA_WIDTH(8), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  pix_t src[$];
  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0, m_cnt = 0, m_mode = 0;
  logic [1:0] cfg_drv = 2'd0;
  bit   full_drv = 0, rnd_on = 0;
  bit   o_wr, o_rd, o_fd, o_full, o_have;
  logic [7:0] o_got;
  exp_t o_exp;

  function automatic logic [7:0] model(int r, int g, int b, int mode);
    int v;
    case (mode)
      1: v = (77 * r + 150 * g + 29 * b) / 256;
      2: begin v = (r > g) ? r : g; v = (v > b) ? v : b; end
      default: v = (r + g + b) / 3;
    endcase
    return 8'(v);
  endfunction

  task automatic drive();
    bus.input_empty = (src.size() == 0) || (rnd_on && $urandom_range(99) < 30);
    if (src.size() > 0) begin
      bus.red = 8'(src[0].r); bus.green = 8'(src[0].g); bus.blue = 8'(src[0].b);
    end
    bus.output_full = rnd_on ? ($urandom_range(99) < 30) : full_drv;
    if (rnd_on) cfg_drv = 2'($urandom_range(3));
    bus.cfg_mode = cfg_drv;
  endtask

  // One cycle: observe outputs, update scoreboard/model, cross the edge, re-drive.
  task automatic step();
    pix_t p;
    #1;
    o_wr = bus.write_fifo; o_rd = bus.read_fifo; o_fd = bus.frame_done;
    o_full = bus.output_full; o_got = bus.gray_image; o_have = 0;
    o_exp = '{8'd0, 1'b0, 0};
    if (o_wr && sb.size() > 0) begin o_exp = sb.pop_front(); o_have = 1; end
    if (o_rd && src.size() > 0) begin
      p = src.pop_front();
      if (m_cnt == 0) m_mode = int'(bus.cfg_mode);
      sb.push_back('{model(p.r, p.g, p.b, m_mode), (m_cnt == FP - 1), cyc});
      m_cnt = (m_cnt + 1) % FP;
    end
    @(posedge clk); cyc++;
    #1 drive();
    @(negedge clk);
  endtask

  task automatic add(int r, int g, int b);
    src.push_back('{r, g, b});
  endtask

  task automatic test_reset();
    bus.input_empty = 1'b0; bus.output_full = 1'b0; bus.cfg_mode = 2'd0;
    bus.red = 8'd1; bus.green = 8'd2; bus.blue = 8'd3;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.read_fifo !== 1'b0) begin n_bad++; $display("FAIL reset read_fifo got %b want 0", bus.read_fifo); end
    n_cmp++; if (bus.write_fifo !== 1'b0) begin n_bad++; $display("FAIL reset write_fifo got %b want 0", bus.write_fifo); end
    n_cmp++; if (bus.gray_image !== 8'd0) begin n_bad++; $display("FAIL reset gray_image got %0d want 0", bus.gray_image); end
    n_cmp++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL reset frame_done got %b want 0", bus.frame_done); end
    @(negedge clk); rst = 1'b0;
    drive();
  endtask

  task automatic test_basic();
    int want[4] = '{60, 255, 0, 1};
    int k = 0;
    cfg_drv = 2'd0;
    add(30, 60, 90); add(255, 255, 255); add(0, 0, 1); add(1, 1, 1);
    drive();
    for (int i = 0; i < 40 && (src.size() > 0 || sb.size() > 0); i++) begin
      step();
      if (o_wr) begin
        n_cmp++; if (!o_have || o_got !== o_exp.gray || k > 3 || o_got !== 8'(want[k & 3])) begin n_bad++; $display("FAIL basic gray[%0d] got %0d want %0d", k, o_got, want[k & 3]); end
        n_cmp++; if (o_fd !== (k == 3)) begin n_bad++; $display("FAIL basic frame_done[%0d] got %b want %b", k, o_fd, k == 3); end
        n_cmp++; if (cyc - 1 - o_exp.cyc != 2) begin n_bad++; $display("FAIL basic latency[%0d] got %0d want 2", k, cyc - 1 - o_exp.cyc); end
        k++;
      end
    end
    n_cmp++; if (k != 4 || sb.size() != 0) begin n_bad++; $display("FAIL basic count got %0d want 4", k); end
  endtask

  task automatic test_modes();
    int want[8] = '{76, 149, 255, 0, 200, 3, 9, 0};
    int k = 0;
    for (int f = 0; f < 2; f++) begin
      cfg_drv = (f == 0) ? 2'd1 : 2'd2;
      if (f == 0) begin add(255, 0, 0); add(0, 255, 0); add(255, 255, 255); add(0, 0, 0); end
      else begin add(10, 200, 7); add(1, 2, 3); add(9, 9, 9); add(0, 0, 0); end
      drive();
      for (int i = 0; i < 40 && (src.size() > 0 || sb.size() > 0); i++) begin
        step();
        if (o_wr) begin
          n_cmp++; if (!o_have || o_got !== o_exp.gray || o_got !== 8'(want[k & 7])) begin n_bad++; $display("FAIL modes gray[%0d] got %0d want %0d", k, o_got, want[k & 7]); end
          n_cmp++; if (o_fd !== o_exp.last) begin n_bad++; $display("FAIL modes frame_done[%0d] got %b want %b", k, o_fd, o_exp.last); end
          k++;
        end
      end
    end
    n_cmp++; if (k != 8) begin n_bad++; $display("FAIL modes count got %0d want 8", k); end
  endtask

  task automatic test_mode_change();
    int want[8] = '{72, 40, 3, 85, 200, 70, 5, 9};
    int k = 0;
    bit popped = 0;
    cfg_drv = 2'd0;
    add(10, 200, 7); add(90, 30, 0); add(3, 3, 3); add(255, 0, 0);
    add(10, 200, 7); add(50, 60, 70); add(5, 5, 5); add(0, 9, 0);
    drive();
    for (int i = 0; i < 60 && (src.size() > 0 || sb.size() > 0); i++) begin
      step();
      if (o_rd && !popped) begin popped = 1; cfg_drv = 2'd2; end
      if (o_wr) begin
        n_cmp++; if (!o_have || o_got !== o_exp.gray || o_got !== 8'(want[k & 7])) begin n_bad++; $display("FAIL mode_change gray[%0d] got %0d want %0d", k, o_got, want[k & 7]); end
        n_cmp++; if (o_fd !== o_exp.last) begin n_bad++; $display("FAIL mode_change frame_done[%0d] got %b want %b", k, o_fd, o_exp.last); end
        k++;
      end
    end
    n_cmp++; if (k != 8) begin n_bad++; $display("FAIL mode_change count got %0d want 8", k); end
  endtask

  task automatic test_stall();
    logic [7:0] held;
    int k = 0;
    cfg_drv = 2'd0;
    add(30, 60, 90); add(12, 0, 0); add(3, 6, 9); add(100, 100, 100);
    add(9, 9, 9); add(0, 3, 0); add(200, 100, 0); add(7, 8, 9);
    drive();
    step(); step();
    full_drv = 1; drive();
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) held = o_got;
      n_cmp++; if (o_wr !== 1'b0 || o_rd !== 1'b0) begin n_bad++; $display("FAIL stall hold[%0d] wr=%b rd=%b want 0/0", i, o_wr, o_rd); end
      n_cmp++; if (o_got !== held) begin n_bad++; $display("FAIL stall gray_stable[%0d] got %0d want %0d", i, o_got, held); end
    end
    full_drv = 0; drive();
    for (int i = 0; i < 40 && (src.size() > 0 || sb.size() > 0); i++) begin
      step();
      if (i < 2) begin
        n_cmp++; if (o_wr !== 1'b1) begin n_bad++; $display("FAIL stall release[%0d] write_fifo got %b want 1", i, o_wr); end
      end
      if (o_wr) begin
        n_cmp++; if (!o_have || o_got !== o_exp.gray) begin n_bad++; $display("FAIL stall gray[%0d] got %0d want %0d", k, o_got, o_exp.gray); end
        n_cmp++; if (o_fd !== o_exp.last) begin n_bad++; $display("FAIL stall frame_done[%0d] got %b want %b", k, o_fd, o_exp.last); end
        k++;
      end
    end
    n_cmp++; if (k != 8) begin n_bad++; $display("FAIL stall count got %0d want 8", k); end
  endtask

  task automatic test_random();
    int k = 0, nfd = 0;
    for (int i = 0; i < 3 * 64; i++) add($urandom_range(255), $urandom_range(255), $urandom_range(255));
    rnd_on = 1; drive();
    for (int i = 0; i < 5000 && (src.size() > 0 || sb.size() > 0); i++) begin
      step();
      if (o_fd) nfd++;
      if (o_wr && o_full) begin n_bad++; $display("FAIL random write_under_full at cycle %0d", cyc); end
      if (o_wr) begin
        n_cmp++; if (!o_have || o_got !== o_exp.gray) begin n_bad++; $display("FAIL random gray[%0d] got %0d want %0d", k, o_got, o_exp.gray); end
        n_cmp++; if (o_fd !== o_exp.last) begin n_bad++; $display("FAIL random frame_done[%0d] got %b want %b", k, o_fd, o_exp.last); end
        k++;
      end
    end
    rnd_on = 0; full_drv = 0; cfg_drv = 2'd0; drive();
    n_cmp++; if (k != 3 * 64) begin n_bad++; $display("FAIL random count got %0d want %0d", k, 3 * 64); end
    n_cmp++; if (nfd != 3 * 64 / FP) begin n_bad++; $display("FAIL random frame_done_pulses got %0d want %0d", nfd, 3 * 64 / FP); end
  endtask

  task automatic test_reset_mid();
    int k = 0, nfd = 0;
    cfg_drv = 2'd1;
    for (int i = 0; i < 2 + 2 * FP; i++) add(10 * i, 255 - 7 * i, 3 * i);
    drive();
    step(); step();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.read_fifo !== 1'b0) begin n_bad++; $display("FAIL rst_mid read_fifo got %b want 0", bus.read_fifo); end
    n_cmp++; if (bus.write_fifo !== 1'b0) begin n_bad++; $display("FAIL rst_mid write_fifo got %b want 0", bus.write_fifo); end
    n_cmp++; if (bus.gray_image !== 8'd0) begin n_bad++; $display("FAIL rst_mid gray_image got %0d want 0", bus.gray_image); end
    n_cmp++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_mid frame_done got %b want 0", bus.frame_done); end
    sb.delete(); m_cnt = 0; m_mode = 0;
    @(negedge clk); rst = 1'b0;
    drive();
    for (int i = 0; i < 60 && (src.size() > 0 || sb.size() > 0); i++) begin
      step();
      if (o_fd) nfd++;
      if (o_wr) begin
        n_cmp++; if (!o_have || o_got !== o_exp.gray) begin n_bad++; $display("FAIL rst_mid gray[%0d] got %0d want %0d", k, o_got, o_exp.gray); end
        n_cmp++; if (o_fd !== ((k % FP) == FP - 1)) begin n_bad++; $display("FAIL rst_mid frame_done[%0d] got %b want %b", k, o_fd, (k % FP) == FP - 1); end
        k++;
      end
    end
    n_cmp++; if (k != 2 * FP || nfd != 2) begin n_bad++; $display("FAIL rst_mid drain pushes %0d pulses %0d want %0d/2", k, nfd, 2 * FP); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_modes();
    test_mode_change();
    test_stall();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
